// File: rtl/eic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eic_pkg
// Purpose  : Shared constants for the EIC AHB-Lite slave: register indices,
//            AHB encodings and slave FSM state encoding.
// Revision : 1.0
// ============================================================================
package eic_pkg;

  localparam int EIC_ADDR_WIDTH = 4;
  localparam int EIC_REG_COUNT  = 13;

  localparam logic [EIC_ADDR_WIDTH-1:0] EICR     = 4'd0;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIMSK_0  = 4'd1;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIMSK_1  = 4'd2;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIFR_0   = 4'd3;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIFR_1   = 4'd4;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIFS_0   = 4'd5;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIFS_1   = 4'd6;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIFC_0   = 4'd7;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIFC_1   = 4'd8;
  localparam logic [EIC_ADDR_WIDTH-1:0] EISMSK_0 = 4'd9;
  localparam logic [EIC_ADDR_WIDTH-1:0] EISMSK_1 = 4'd10;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIIPR_0  = 4'd11;
  localparam logic [EIC_ADDR_WIDTH-1:0] EIIPR_1  = 4'd12;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_ERR1  = 3'd4;
  localparam logic [2:0] S_ERR2  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/eic_ahb_slave.sv
`default_nettype none
// ============================================================================
// Module   : eic_ahb_slave
// Purpose  : AHB-Lite slave front end sequencing bus transfers into the EIC
//            register-access port, with optional read wait and ERROR replies.
// Revision : 1.0
// ============================================================================
module eic_ahb_slave #(
  parameter int EIC_ADDR_WIDTH = 4,
  parameter int EIC_REG_COUNT  = 13,
  parameter int READ_WAIT      = 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic                      HWRITE,
  input  logic                      HREADY,
  input  logic [31:0]               HWDATA,
  output logic [31:0]               HRDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [EIC_ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]               read_data,
  output logic [EIC_ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]               write_data,
  output logic                      write_enable
);

  import eic_pkg::*;

  logic [2:0]                r_state;
  logic [2:0]                w_next_state;
  logic [EIC_ADDR_WIDTH-1:0] r_read_addr;
  logic [EIC_ADDR_WIDTH-1:0] r_write_addr;
  logic [EIC_ADDR_WIDTH-1:0] w_index;
  logic [31:0]               w_index_ext;
  logic                      w_open;
  logic                      w_accept;
  logic                      w_illegal;
  logic                      w_unused;

  assign w_index     = HADDR[EIC_ADDR_WIDTH+1:2];
  assign w_index_ext = {{(32-EIC_ADDR_WIDTH){1'b0}}, w_index};
  assign w_unused    = ^{HADDR[31:EIC_ADDR_WIDTH+2], HTRANS[0]};

  // Only cycles that end a data phase (HREADYOUT high) may take a new address phase.
  assign w_open    = (r_state == S_IDLE) || (r_state == S_WRITE) ||
                     (r_state == S_READ) || (r_state == S_ERR2);
  assign w_accept  = w_open & HSEL & HREADY & HTRANS[1];
  assign w_illegal = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00) ||
                     (w_index_ext >= 32'(EIC_REG_COUNT));

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_RWAIT: w_next_state = S_READ;
      S_ERR1:  w_next_state = S_ERR2;
      default: begin
        if (w_accept) begin
          if (w_illegal)           w_next_state = S_ERR1;
          else if (HWRITE)         w_next_state = S_WRITE;
          else if (READ_WAIT != 0) w_next_state = S_RWAIT;
          else                     w_next_state = S_READ;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_read_addr  <= '0;
      r_write_addr <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_read_addr  <= w_index;
        r_write_addr <= w_index;
      end
    end
  end

  assign HREADYOUT    = (r_state != S_RWAIT) && (r_state != S_ERR1);
  assign HRESP        = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign write_enable = (r_state == S_WRITE);
  assign write_addr   = r_write_addr;
  assign write_data   = HWDATA;
  assign read_addr    = r_read_addr;

  generate
    if (READ_WAIT != 0) begin : g_rdata_reg
      logic [31:0] r_hrdata;
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                   r_hrdata <= '0;
        else if (r_state == S_RWAIT) r_hrdata <= read_data;
      end
      assign HRDATA = r_hrdata;
    end else begin : g_rdata_comb
      assign HRDATA = (r_state == S_READ) ? read_data : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_eic_ahb_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_eic_ahb_slave
// Purpose  : Scoreboard bench for eic_ahb_slave with a simple EIC register model.
// Revision : 1.0
// ============================================================================
module tb_eic_ahb_slave;

  import eic_pkg::*;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;
  localparam int RW    = 1;

  typedef struct {
    int          kind;
    logic [3:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = HTRANS_IDLE;
  logic [2:0]  HSIZE = HSIZE_WORD;
  logic        HWRITE = 1'b0;
  logic        HREADY;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic        hready_force = 1'b1;

  logic [31:0] eic_regs [16] = '{default: 32'h0};
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 CLK = ~CLK;

  assign HREADY    = HREADYOUT & hready_force;
  assign read_data = eic_regs[read_addr];

  always @(posedge CLK) begin
    if (write_enable) eic_regs[write_addr] <= write_data;
  end

  eic_ahb_slave #(
    .EIC_ADDR_WIDTH(4),
    .EIC_REG_COUNT (13),
    .READ_WAIT     (RW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSIZE       (HSIZE),
    .HWRITE      (HWRITE),
    .HREADY      (HREADY),
    .HWDATA      (HWDATA),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_enable(write_enable)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one address phase, waits for acceptance, then moves to its data phase.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input int kind, input logic [31:0] exp_data);
    bit ok;
    exp_t e;
    HSEL   = 1'b1;
    HADDR  = addr;
    HTRANS = HTRANS_NONSEQ;
    HSIZE  = size;
    HWRITE = wr;
    e.kind = kind;
    e.idx  = addr[5:2];
    e.data = exp_data;
    sb.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (HREADY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got no HREADY, expected acceptance of %h", addr);
    end
    @(posedge CLK);
    #1;
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    if (wr) HWDATA = wdata;
  endtask

  // Monitor: tracks data phases and compares against the scoreboard on completion.
  initial begin
    bit   in_dp;
    bit   err_seen;
    int   waits;
    exp_t e;
    in_dp = 1'b0;
    err_seen = 1'b0;
    waits = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        if (in_dp && sb.size() > 0) e = sb.pop_front();
        in_dp = 1'b0;
        err_seen = 1'b0;
        waits = 0;
      end else begin
        if (in_dp) begin
          if (!HREADYOUT) begin
            waits++;
            if (HRESP) err_seen = 1'b1;
            chk("we_during_wait", {31'b0, write_enable}, 32'd0);
          end else begin
            if (sb.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL sb_empty: got a completed data phase, expected none");
            end else begin
              e = sb.pop_front();
              case (e.kind)
                K_WR: begin
                  chk("wr_we", {31'b0, write_enable}, 32'd1);
                  chk("wr_addr", {28'b0, write_addr}, {28'b0, e.idx});
                  chk("wr_data", write_data, e.data);
                  chk("wr_resp", {31'b0, HRESP}, 32'd0);
                  chk("wr_waits", waits, 32'd0);
                end
                K_RD: begin
                  chk("rd_data", HRDATA, e.data);
                  chk("rd_resp", {31'b0, HRESP}, 32'd0);
                  chk("rd_waits", waits, RW);
                end
                default: begin
                  chk("err_first", {31'b0, err_seen}, 32'd1);
                  chk("err_second", {31'b0, HRESP}, 32'd1);
                  chk("err_waits", waits, 32'd1);
                  chk("err_we", {31'b0, write_enable}, 32'd0);
                end
              endcase
            end
            in_dp = 1'b0;
            err_seen = 1'b0;
            waits = 0;
          end
        end else begin
          chk("idle_ready", {31'b0, HREADYOUT}, 32'd1);
          chk("idle_resp", {31'b0, HRESP}, 32'd0);
          chk("idle_we", {31'b0, write_enable}, 32'd0);
        end
        if (HREADYOUT) in_dp = HSEL & HREADY & HTRANS[1];
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, {31'b0, HREADYOUT}, 32'd1);
    chk({tag, "_hresp"}, {31'b0, HRESP}, 32'd0);
    chk({tag, "_hrdata"}, HRDATA, 32'd0);
    chk({tag, "_we"}, {31'b0, write_enable}, 32'd0);
    chk({tag, "_raddr"}, {28'b0, read_addr}, 32'd0);
    chk({tag, "_waddr"}, {28'b0, write_addr}, 32'd0);
  endtask

  initial begin
    #3;
    chk_reset_outputs("rst");
    #9 RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Write then read with one wait state
    xfer(1'b1, 32'h04, HSIZE_WORD, 32'h0000_00FF, K_WR, 32'h0000_00FF);
    idle(2);
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'h0, K_RD, 32'h0000_00FF);
    idle(2);

    // Back-to-back write then read of EISMSK_0
    xfer(1'b1, 32'h24, HSIZE_WORD, 32'hAAAA_AAAA, K_WR, 32'hAAAA_AAAA);
    xfer(1'b0, 32'h24, HSIZE_WORD, 32'h0, K_RD, 32'hAAAA_AAAA);
    idle(2);

    // Illegal: byte write, out-of-range read, unaligned write
    xfer(1'b1, 32'h08, 3'b000, 32'h1234_5678, K_ERR, 32'h0);
    idle(1);
    xfer(1'b0, 32'h34, HSIZE_WORD, 32'h0, K_ERR, 32'h0);
    idle(1);
    xfer(1'b0, 32'h08, HSIZE_WORD, 32'h0, K_RD, 32'h0);
    xfer(1'b1, 32'h06, HSIZE_WORD, 32'h5555_5555, K_ERR, 32'h0);
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'h0, K_RD, 32'h0000_00FF);
    idle(1);

    // Legal read taken in the second error cycle
    xfer(1'b0, 32'h34, HSIZE_WORD, 32'h0, K_ERR, 32'h0);
    xfer(1'b0, 32'h24, HSIZE_WORD, 32'h0, K_RD, 32'hAAAA_AAAA);
    idle(1);

    // Non-transfers: BUSY, unselected, HREADY low
    HSEL = 1'b1; HTRANS = HTRANS_BUSY; HWRITE = 1'b1; HADDR = 32'h04;
    @(posedge CLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_NONSEQ;
    @(posedge CLK); #1;
    HSEL = 1'b1; hready_force = 1'b0;
    @(posedge CLK); #1;
    hready_force = 1'b1;
    HWRITE = 1'b0;
    idle(2);

    // Reset during the read wait state
    xfer(1'b0, 32'h24, HSIZE_WORD, 32'h0, K_RD, 32'hAAAA_AAAA);
    #1 RESET = 1'b1;
    #1 chk_reset_outputs("rst_rwait");
    @(negedge CLK);
    #1 RESET = 1'b0;
    idle(2);

    // Reset during the first error cycle
    xfer(1'b0, 32'h34, HSIZE_WORD, 32'h0, K_ERR, 32'h0);
    #1 RESET = 1'b1;
    #1 chk_reset_outputs("rst_err1");
    @(negedge CLK);
    #1 RESET = 1'b0;
    idle(2);

    xfer(1'b0, 32'h24, HSIZE_WORD, 32'h0, K_RD, 32'hAAAA_AAAA);
    idle(4);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/eic_ahb_slave.md
Name: eic_ahb_slave

Overview:
AHB-Lite slave front end that sequences bus transfers into the EIC register-access port. It converts AHB address/data phases into `read_addr`, `write_addr`, `write_data` and `write_enable`, and returns `read_data` on `HRDATA`. It inserts optional read wait states and generates two-cycle ERROR responses for illegal accesses. It sits between the system AHB-Lite interconnect and the EIC core.

Parameters:
- EIC_ADDR_WIDTH, 4, width of the register index driven to the EIC (index taken from HADDR[EIC_ADDR_WIDTH+1:2]).
- EIC_REG_COUNT, 13, number of implemented registers (indices 0..EIC_REG_COUNT-1); higher indices are illegal.
- READ_WAIT, 1, 0 = combinational HRDATA with zero-wait reads; 1 = registered HRDATA with one wait state per read.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
- HSIZE  in  3  transfer size.
- HWRITE  in  1  1 = write.
- HREADY  in  1  bus-level ready (address phase qualifier).
- HWDATA  in  32  write data (data phase).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- read_addr  out  EIC_ADDR_WIDTH  EIC register read index.
- read_data  in  32  EIC register read value (combinational from read_addr).
- write_addr  out  EIC_ADDR_WIDTH  EIC register write index.
- write_data  out  32  EIC write data.
- write_enable  out  1  one-cycle write strobe.

Behaviour:
- Reset: clock CLK; reset RESET, asynchronous and active-high. During reset:
  - state = S_IDLE;
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0;
  - write_enable = 0;
  - read_addr = 0, write_addr = 0.
- Transfer acceptance: a transfer is accepted when HSEL & HREADY & HTRANS[1] at a rising edge. Address-phase signals are registered only on acceptance.
- Illegal transfer: any of HSIZE != 3'b010, HADDR[1:0] != 0, or index >= EIC_REG_COUNT.
- FSM states: S_IDLE, S_WRITE, S_READ, S_RWAIT, S_ERR1, S_ERR2.
- Next state:
  - Legal write accepted -> S_WRITE.
  - Legal read accepted -> S_RWAIT if READ_WAIT = 1, else S_READ.
  - Illegal transfer accepted -> S_ERR1.
  - No acceptance -> S_IDLE.
  - The next-state rule is evaluated in S_IDLE, S_WRITE, S_READ and S_ERR2. These are the cycles where HREADYOUT = 1, so back-to-back pipelined transfers are supported.
- S_WRITE:
  - write_enable = 1, write_addr = latched index, write_data = HWDATA (passed through).
  - HREADYOUT = 1, HRESP = 0.
  - The EIC updates at the end of this cycle.
- S_READ (READ_WAIT = 0):
  - HRDATA = read_data (combinational), HREADYOUT = 1.
- S_RWAIT:
  - HREADYOUT = 0; read_data is captured into the HRDATA register at the end of the cycle.
  - Always -> S_READ, which then drives the registered HRDATA with HREADYOUT = 1.
- read_addr: loaded from the accepted address phase and held through the data phase.
- Read after write: a read accepted in the same cycle as a write's data phase returns the post-write value, because the read data phase starts after the write commits. No extra stall is needed.
- S_ERR1: HREADYOUT = 0, HRESP = 1, write_enable = 0. Always -> S_ERR2.
- S_ERR2: HREADYOUT = 1, HRESP = 1. Any transfer accepted here is processed normally.
- Write suppression: an illegal write never asserts write_enable.
- IDLE/BUSY transfers and HSEL = 0: no state change, zero-wait OKAY.
- HRDATA outside read data phases: holds its last value (READ_WAIT = 1); reads 0 in non-read states (READ_WAIT = 0).
- Reset mid-transfer: immediate return to S_IDLE. A pending write is dropped and write_enable deasserts asynchronously.

Decomposition:
- Shared package eic_pkg holds:
  - register index constants (EICR = 0 … EIIPR_1 = 12), EIC_REG_COUNT, EIC_ADDR_WIDTH;
  - HTRANS encodings (IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3), HSIZE_WORD = 3'b010, HRESP_OKAY/ERROR;
  - FSM state encoding.
- No sub-module: single module, FSM plus address-phase registers.

Test Plan:
- Write then read: NONSEQ write HADDR=0x04, HWDATA=0x0000_00FF; then read 0x04 with READ_WAIT=1 -> write_enable pulses one cycle with write_addr=1 and write_data=0xFF; read sees HREADYOUT low for 1 cycle, then HRDATA=0xFF with HRESP=0.
- Back-to-back write-to-read: write 0x24 (EISMSK_0) = 0xAAAA_AAAA immediately followed by read 0x24, no idle between -> read returns 0xAAAA_AAAA; no stall beyond READ_WAIT.
- Illegal accesses: byte write (HSIZE=0) to 0x08, and read of 0x34 (index 13) -> each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; write_enable never asserts.
- Unaligned address: write with HADDR=0x06 -> ERROR response; EIC register unchanged on readback of 0x04.
- Non-transfers: HTRANS=BUSY, HSEL=0 and HREADY=0 cycles -> HREADYOUT=1, HRESP=0, no write_enable, state stays S_IDLE.
- Reset mid-transfer: assert RESET during S_RWAIT and during S_ERR1 -> outputs return to reset values in the same cycle; the next legal read completes normally.
